// File: rtl/uart_frame_dispatch.sv
// uart_frame_dispatch: packs UART bytes into 32-bit words, decodes config/launch frames and gates launch pulses.
// Optional inter-byte timeout abort is compiled in with `define FRAME_TIMEOUT_EN.
module uart_frame_dispatch #(
    parameter int NUM_CHANNEL    = 4,
    parameter int DEPTH          = 2,
    parameter int LAUNCH_WORDS   = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [7:0]                         i_rx_data,
    input  logic                               i_rx_valid,
    input  logic [NUM_CHANNEL-1:0]             i_ch_idle,
    output logic [NUM_CHANNEL-1:0]             o_cfg_we,
    output logic [$clog2(DEPTH*3+2)-1:0]       o_cfg_addr,
    output logic [31:0]                        o_cfg_data,
    output logic [NUM_CHANNEL-1:0]             o_launch,
    output logic [32*LAUNCH_WORDS-1:0]         o_launch_regs,
    output logic                               o_busy,
    output logic                               o_err,
    output logic [1:0]                         o_err_code
);
    localparam int TOTAL_REGS = DEPTH * 3 + 2;
    localparam int AW         = $clog2(TOTAL_REGS);
    localparam int MAXW       = TOTAL_REGS > LAUNCH_WORDS ? TOTAL_REGS : LAUNCH_WORDS;
    localparam int WCW        = $clog2(MAXW);
    localparam int CHW        = NUM_CHANNEL > 1 ? $clog2(NUM_CHANNEL) : 1;

    typedef enum logic [1:0] {S_HDR, S_CFG, S_LAUNCH, S_LWAIT} state_t;

    state_t                 state, state_n;
    logic [1:0]             byte_cnt, byte_cnt_n;
    logic [WCW-1:0]         word_cnt, word_cnt_n;
    logic [23:0]            byte_sr;
    logic [CHW-1:0]         ch, ch_n, hdr_ch;
    logic                   cfg_ok, cfg_ok_n, hdr_hit;
    logic [NUM_CHANNEL-1:0] mask, mask_n, cfg_we_n;
    logic [1:0]             err_n;
    logic                   acc, wd, go, tmo;
    logic [31:0]            word;

    // Bytes arriving while a launch is pending are dropped, never shifted in.
    assign acc    = i_rx_valid && state != S_LWAIT;
    assign wd     = acc && byte_cnt == 2'd3;
    assign word   = {byte_sr, i_rx_data};
    assign go     = (i_ch_idle & mask) == mask;
    assign o_busy = state != S_HDR || byte_cnt != 2'd0;

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr;
    logic          armed;
    assign armed = (state == S_HDR && byte_cnt != 2'd0) || state == S_CFG || state == S_LAUNCH;
    assign tmo   = armed && !i_rx_valid && tmr == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge i_clk)
        tmr <= (i_rst || i_rx_valid || !armed || tmo) ? '0 : tmr + 1'b1;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        hdr_hit = 1'b0;
        hdr_ch  = '0;
        for (int i = 0; i < NUM_CHANNEL; i++)
            if (word == ~(32'd1 << (i + 8))) begin
                hdr_hit = 1'b1;
                hdr_ch  = CHW'(i);
            end
    end

    always_comb begin
        state_n    = state;
        byte_cnt_n = acc ? byte_cnt + 2'd1 : byte_cnt;
        word_cnt_n = word_cnt;
        ch_n       = ch;
        cfg_ok_n   = cfg_ok;
        mask_n     = mask;
        cfg_we_n   = '0;
        err_n      = 2'd0;
        o_launch   = '0;
        case (state)
            S_HDR: if (wd) begin
                word_cnt_n = '0;
                if (word == 32'hFFFF_FFFF) state_n = S_LAUNCH;
                else if (hdr_hit) begin
                    state_n  = S_CFG;
                    ch_n     = hdr_ch;
                    cfg_ok_n = i_ch_idle[hdr_ch];
                    err_n    = i_ch_idle[hdr_ch] ? 2'd0 : 2'd2;
                end else err_n = 2'd1;
            end
            S_CFG: if (wd) begin
                cfg_we_n   = cfg_ok ? NUM_CHANNEL'(1) << ch : '0;
                word_cnt_n = word_cnt + 1'b1;
                if (word_cnt == WCW'(TOTAL_REGS - 1)) begin
                    state_n    = S_HDR;
                    word_cnt_n = '0;
                end
            end
            S_LAUNCH: if (wd) begin
                if (word_cnt == '0) mask_n = word[NUM_CHANNEL-1:0];
                word_cnt_n = word_cnt + 1'b1;
                if (word_cnt == WCW'(LAUNCH_WORDS - 1)) begin
                    state_n    = S_LWAIT;
                    word_cnt_n = '0;
                end
            end
            default: begin
                err_n    = i_rx_valid ? 2'd3 : 2'd0;
                o_launch = go ? mask : '0;
                state_n  = go ? S_HDR : S_LWAIT;
            end
        endcase
        if (tmo) begin
            state_n    = S_HDR;
            byte_cnt_n = 2'd0;
            word_cnt_n = '0;
            err_n      = 2'd3;
        end
    end

    always_ff @(posedge i_clk)
        if (i_rst) begin
            state      <= S_HDR;
            byte_cnt   <= 2'd0;
            word_cnt   <= '0;
            byte_sr    <= '0;
            ch         <= '0;
            cfg_ok     <= 1'b0;
            mask       <= '0;
            o_cfg_we   <= '0;
            o_cfg_addr <= '0;
            o_cfg_data <= '0;
            o_err      <= 1'b0;
            o_err_code <= 2'd0;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_cnt_n;
            word_cnt <= word_cnt_n;
            ch       <= ch_n;
            cfg_ok   <= cfg_ok_n;
            mask     <= mask_n;
            o_cfg_we <= cfg_we_n;
            o_err    <= err_n != 2'd0;
            if (acc) byte_sr <= {byte_sr[15:0], i_rx_data};
            if (state == S_CFG && wd) begin
                o_cfg_addr <= word_cnt[AW-1:0];
                o_cfg_data <= word;
            end
            if (err_n != 2'd0) o_err_code <= err_n;
        end

    always_ff @(posedge i_clk)
        if (i_rst) o_launch_regs <= '0;
        else
            for (int k = 0; k < LAUNCH_WORDS; k++)
                if (state == S_LAUNCH && wd && word_cnt == WCW'(k))
                    o_launch_regs[32*k +: 32] <= word;
endmodule

// File: tb/tb_uart_frame_dispatch.sv
// tb_uart_frame_dispatch: randomized frame stimulus checked against expected writes/launches/errors derived from frame rules.
module tb_uart_frame_dispatch;
    localparam int NC = 4, DEPTH = 2, TR = DEPTH * 3 + 2, LW = 4, TO = 100, AW = $clog2(TR);

    logic                 i_clk = 1'b0, i_rst = 1'b1, i_rx_valid = 1'b0;
    logic [7:0]           i_rx_data = 8'd0;
    logic [NC-1:0]        i_ch_idle = '1;
    logic [NC-1:0]        o_cfg_we, o_launch;
    logic [AW-1:0]        o_cfg_addr;
    logic [31:0]          o_cfg_data;
    logic [32*LW-1:0]     o_launch_regs;
    logic                 o_busy, o_err;
    logic [1:0]           o_err_code;

    int checks = 0, failures = 0, gap_max = 0;
    logic [NC+AW+31:0] cfg_q[$];
    logic [NC-1:0]     launch_q[$];
    logic [1:0]        err_q[$];

    uart_frame_dispatch #(.NUM_CHANNEL(NC), .DEPTH(DEPTH), .LAUNCH_WORDS(LW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_ch_idle(i_ch_idle),
        .o_cfg_we(o_cfg_we), .o_cfg_addr(o_cfg_addr), .o_cfg_data(o_cfg_data), .o_launch(o_launch),
        .o_launch_regs(o_launch_regs), .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code));

    always #5 i_clk = ~i_clk;

    // Event log observed on the falling edge, compared against expectations after each scenario.
    always @(negedge i_clk)
        if (!i_rst) begin
            if (|o_cfg_we) cfg_q.push_back({o_cfg_we, o_cfg_addr, o_cfg_data});
            if (|o_launch) launch_q.push_back(o_launch);
            if (o_err) err_q.push_back(o_err_code);
        end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_data = b; i_rx_valid = 1'b1;
        tick(1);
        i_rx_valid = 1'b0;
        if (gap_max > 0) tick(int'($urandom_range(gap_max)));
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(8'(w >> (8 * i)));
    endtask

    task automatic flush();
        cfg_q.delete(); launch_q.delete(); err_q.delete();
    endtask

    function automatic logic [31:0] cfg_hdr(input int c);
        return 32'hFFFF_FFFF ^ (32'd1 << (c + 8));
    endfunction

    task automatic test_reset();
        checks++; if (o_cfg_we !== '0) begin failures++; $display("FAIL reset_cfg_we got=%h exp=0", o_cfg_we); end
        checks++; if (o_launch !== '0) begin failures++; $display("FAIL reset_launch got=%h exp=0", o_launch); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
        checks++; if (o_err !== 1'b0 || o_err_code !== 2'd0) begin failures++; $display("FAIL reset_err got=%b/%0d exp=0/0", o_err, o_err_code); end
        checks++; if (o_launch_regs !== '0) begin failures++; $display("FAIL reset_launch_regs got=%h exp=0", o_launch_regs); end
        checks++; if (o_cfg_addr !== '0 || o_cfg_data !== '0) begin failures++; $display("FAIL reset_cfg_bus got=%h/%h exp=0/0", o_cfg_addr, o_cfg_data); end
    endtask

    task automatic test_cfg();
        logic [31:0] d [TR];
        logic [NC+AW+31:0] exp;
        int c;
        for (int it = 0; it < 5; it++) begin
            c = (it == 0) ? 2 : int'($urandom_range(NC - 1));
            gap_max = (it < 2) ? 0 : 3;
            i_ch_idle = NC'($urandom) | (NC'(1) << c);
            flush();
            send_word(cfg_hdr(c));
            for (int j = 0; j < TR; j++) begin
                d[j] = (it == 0) ? 32'(j) : $urandom;
                send_word(d[j]);
            end
            tick(1);
            checks++; if (cfg_q.size() !== TR) begin failures++; $display("FAIL cfg_count it=%0d got=%0d exp=%0d", it, cfg_q.size(), TR); end
            for (int j = 0; j < TR; j++) begin
                exp = {NC'(1) << c, AW'(j), d[j]};
                checks++;
                if (j >= cfg_q.size() || cfg_q[j] !== exp) begin
                    failures++; $display("FAIL cfg_write it=%0d j=%0d got=%h exp=%h", it, j, (j < cfg_q.size()) ? cfg_q[j] : '0, exp);
                end
            end
            checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL cfg_noerr it=%0d got=%0d errors exp=0", it, err_q.size()); end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL cfg_busy_end it=%0d got=%b exp=0", it, o_busy); end
        end
        gap_max = 0;
    endtask

    task automatic test_cfg_busy();
        logic [31:0] w;
        int c;
        for (int it = 0; it < 2; it++) begin
            c = (it == 0) ? 1 : int'($urandom_range(NC - 1));
            i_ch_idle = '1 & ~(NC'(1) << c);
            flush();
            send_word(cfg_hdr(c));
            i_ch_idle = '1;
            for (int j = 0; j < TR; j++) begin
                w = $urandom;
                send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]);
                if (j == TR - 1) begin
                    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL busy_35 got=%b exp=1", o_busy); end
                end
                send_byte(w[7:0]);
            end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL busy_36 got=%b exp=0", o_busy); end
            tick(1);
            checks++; if (cfg_q.size() !== 0) begin failures++; $display("FAIL busy_no_we got=%0d writes exp=0", cfg_q.size()); end
            checks++; if (err_q.size() !== 1 || err_q[0] !== 2'd2) begin failures++; $display("FAIL busy_err got=%0d events code=%0d exp=1 events code=2", err_q.size(), o_err_code); end
            checks++; if (o_err_code !== 2'd2) begin failures++; $display("FAIL busy_code_held got=%0d exp=2", o_err_code); end
        end
    endtask

    task automatic test_bad_header();
        logic [31:0] h;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) h = 32'h1234_5678;
            else if (it == 1) h = cfg_hdr(NC);
            else h = $urandom;
            flush();
            send_word(h);
            tick(1);
            checks++; if (err_q.size() !== 1 || err_q[0] !== 2'd1) begin failures++; $display("FAIL badhdr_err h=%h got=%0d events code=%0d exp=1 event code=1", h, err_q.size(), o_err_code); end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL badhdr_state h=%h busy got=%b exp=0", h, o_busy); end
        end
        i_ch_idle = '1;
        flush();
        send_word(cfg_hdr(0));
        for (int j = 0; j < TR; j++) send_word(32'hA000_0000 + 32'(j));
        tick(1);
        checks++; if (cfg_q.size() !== TR) begin failures++; $display("FAIL badhdr_resync got=%0d writes exp=%0d", cfg_q.size(), TR); end
        checks++; if (cfg_q.size() == TR && cfg_q[TR-1] !== {NC'(1), AW'(TR - 1), 32'hA000_0000 + 32'(TR - 1)}) begin
            failures++; $display("FAIL badhdr_resync_last got=%h", cfg_q[TR-1]);
        end
        checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL badhdr_resync_err got=%0d exp=0", err_q.size()); end
    endtask

    task automatic test_launch();
        logic [31:0] w [LW];
        logic [32*LW-1:0] exp_regs;
        logic [NC-1:0] m;
        for (int it = 0; it < 5; it++) begin
            for (int k = 0; k < LW; k++) w[k] = (it == 0) ? ((k == 0) ? 32'h5 : 32'h0) : $urandom;
            if (it == 1) w[0][NC-1:0] = '0;
            m = w[0][NC-1:0];
            exp_regs = '0;
            for (int k = 0; k < LW; k++) exp_regs = {w[k], exp_regs[32*LW-1:32]};
            i_ch_idle = '1;
            flush();
            send_word(32'hFFFF_FFFF);
            for (int k = 0; k < LW; k++) send_word(w[k]);
            checks++; if (o_launch !== m) begin failures++; $display("FAIL launch_pulse it=%0d got=%h exp=%h", it, o_launch, m); end
            tick(1);
            checks++; if (o_launch !== '0) begin failures++; $display("FAIL launch_one_cycle it=%0d got=%h exp=0", it, o_launch); end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL launch_busy it=%0d got=%b exp=0", it, o_busy); end
            checks++; if (o_launch_regs !== exp_regs) begin failures++; $display("FAIL launch_regs it=%0d got=%h exp=%h", it, o_launch_regs, exp_regs); end
            checks++; if (launch_q.size() !== ((m != '0) ? 1 : 0)) begin failures++; $display("FAIL launch_count it=%0d got=%0d", it, launch_q.size()); end
            checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL launch_noerr it=%0d got=%0d exp=0", it, err_q.size()); end
        end
    endtask

    task automatic test_launch_wait();
        logic [31:0] w [LW];
        logic [32*LW-1:0] exp_regs;
        int c;
        for (int k = 0; k < LW; k++) w[k] = (k == 0) ? 32'h1 : $urandom;
        exp_regs = '0;
        for (int k = 0; k < LW; k++) exp_regs = {w[k], exp_regs[32*LW-1:32]};
        i_ch_idle = 4'b1110;
        flush();
        send_word(32'hFFFF_FFFF);
        for (int k = 0; k < LW; k++) send_word(w[k]);
        for (int n = 0; n < 50; n++) begin
            checks++; if (o_launch !== '0) begin failures++; $display("FAIL lwait_hold n=%0d got=%h exp=0", n, o_launch); end
            if (n == 20) send_byte(8'h3C); else tick(1);
        end
        checks++; if (err_q.size() !== 1 || o_err_code !== 2'd3) begin failures++; $display("FAIL lwait_overrun got=%0d events code=%0d exp=1 code=3", err_q.size(), o_err_code); end
        i_ch_idle = '1;
        i_rx_data = 8'hFF; i_rx_valid = 1'b1;
        #1;
        checks++; if (o_launch !== 4'b0001) begin failures++; $display("FAIL lwait_pulse got=%h exp=1", o_launch); end
        tick(1);
        i_rx_valid = 1'b0;
        checks++; if (o_launch !== '0) begin failures++; $display("FAIL lwait_pulse_end got=%h exp=0", o_launch); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL lwait_drop_busy got=%b exp=0", o_busy); end
        tick(1);
        checks++; if (launch_q.size() !== 1) begin failures++; $display("FAIL lwait_count got=%0d exp=1", launch_q.size()); end
        checks++; if (err_q.size() !== 2 || err_q[1] !== 2'd3) begin failures++; $display("FAIL lwait_same_cycle_overrun got=%0d events exp=2", err_q.size()); end
        c = int'($urandom_range(NC - 1));
        send_word(cfg_hdr(c));
        for (int j = 0; j < TR; j++) send_word($urandom);
        tick(1);
        checks++; if (o_launch_regs !== exp_regs) begin failures++; $display("FAIL lregs_survive got=%h exp=%h", o_launch_regs, exp_regs); end
        checks++; if (cfg_q.size() !== TR) begin failures++; $display("FAIL lregs_cfg_count got=%0d exp=%0d", cfg_q.size(), TR); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [TR];
        logic [31:0] w [LW];
        int c;
        c = int'($urandom_range(NC - 1));
        for (int j = 0; j < TR; j++) d[j] = $urandom;
        for (int k = 0; k < LW; k++) w[k] = $urandom;
        i_ch_idle = '1;
        flush();
        send_word(cfg_hdr(c));
        for (int j = 0; j < TR; j++) send_word(d[j]);
        send_word(32'hFFFF_FFFF);
        for (int k = 0; k < LW; k++) send_word(w[k]);
        tick(1);
        send_word(cfg_hdr(NC - 1 - c));
        for (int j = 0; j < TR; j++) send_word(~d[j]);
        tick(1);
        checks++; if (cfg_q.size() !== 2 * TR) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", cfg_q.size(), 2 * TR); end
        for (int j = 0; j < TR && cfg_q.size() == 2 * TR; j++) begin
            checks++; if (cfg_q[j] !== {NC'(1) << c, AW'(j), d[j]}) begin failures++; $display("FAIL b2b_first j=%0d got=%h", j, cfg_q[j]); end
            checks++; if (cfg_q[TR+j] !== {NC'(1) << (NC - 1 - c), AW'(j), ~d[j]}) begin failures++; $display("FAIL b2b_second j=%0d got=%h", j, cfg_q[TR+j]); end
        end
        checks++; if (launch_q.size() !== ((w[0][NC-1:0] != '0) ? 1 : 0)) begin failures++; $display("FAIL b2b_launch got=%0d", launch_q.size()); end
        checks++; if (err_q.size() !== 0) begin failures++; $display("FAIL b2b_noerr got=%0d exp=0", err_q.size()); end
    endtask

    task automatic test_reset_mid();
        flush();
        send_word(32'hFFFF_FFFF);
        send_word($urandom); send_word($urandom);
        send_byte(8'hFF); send_byte(8'hFF);
        i_rst = 1'b1;
        tick(2);
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", o_busy); end
        checks++; if (o_launch_regs !== '0) begin failures++; $display("FAIL rstmid_lregs got=%h exp=0", o_launch_regs); end
        checks++; if (o_err_code !== 2'd0) begin failures++; $display("FAIL rstmid_code got=%0d exp=0", o_err_code); end
        i_rst = 1'b0;
        send_word(cfg_hdr(3));
        for (int j = 0; j < TR; j++) send_word(32'(j * 3));
        tick(1);
        checks++; if (cfg_q.size() !== TR) begin failures++; $display("FAIL rstmid_resync got=%0d exp=%0d", cfg_q.size(), TR); end
        checks++; if (launch_q.size() !== 0 || err_q.size() !== 0) begin failures++; $display("FAIL rstmid_strobes launches=%0d errors=%0d exp=0/0", launch_q.size(), err_q.size()); end
    endtask

`ifdef FRAME_TIMEOUT_EN
    task automatic test_timeout();
        flush();
        send_byte(8'hFF); send_byte(8'hFF);
        tick(TO - 1);
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", o_err); end
        tick(1);
        checks++; if (o_err !== 1'b1 || o_err_code !== 2'd3) begin failures++; $display("FAIL tmo_fire got=%b/%0d exp=1/3", o_err, o_err_code); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL tmo_busy got=%b exp=0", o_busy); end
        send_word(cfg_hdr(1));
        for (int j = 0; j < TR; j++) send_word(32'(j));
        tick(1);
        checks++; if (cfg_q.size() !== TR) begin failures++; $display("FAIL tmo_resync got=%0d exp=%0d", cfg_q.size(), TR); end
    endtask
`endif

    initial begin
        tick(3);
        test_reset();
        i_rst = 1'b0;
        tick(1);
        test_cfg();
        test_cfg_busy();
        test_bad_header();
        test_launch();
        test_launch_wait();
        test_back_to_back();
        test_reset_mid();
`ifdef FRAME_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
